// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory arbiter.
// Imported by the arbiter top.
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } arbState_t;

endpackage

// File: rtl/unified_mem_arbiter.sv
// Serialises fetch and load/store accesses onto one single-ported memory, buffers the
// results and freezes the pipeline until every access the current cycle needs is complete.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] PCF,
   input  logic              FetchReqF,
   input  logic [ADDR_W-1:0] ALUResultM,
   input  logic [DATA_W-1:0] WriteDataM,
   input  logic              MemWriteM,
   input  logic              MemReadM,
   output logic [DATA_W-1:0] InstrF,
   output logic [DATA_W-1:0] ReadDataM,
   output logic              ArbStall,
   output logic              MemReq,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWData,
   input  logic              MemGnt,
   input  logic              MemRValid,
   input  logic [DATA_W-1:0] MemRData
);

   arbState_t state;
   logic      iValid;
   logic      dValid;
   logic      curIsData;
   logic      dataReq;

   assign dataReq  = MemReadM | MemWriteM;
   assign ArbStall = (FetchReqF & ~iValid) | (dataReq & ~dValid);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         iValid    <= 1'b0;
         dValid    <= 1'b0;
         curIsData <= 1'b0;
         MemReq    <= 1'b0;
         MemWe     <= 1'b0;
         MemAddr   <= '0;
         MemWData  <= '0;
         InstrF    <= '0;
         ReadDataM <= '0;
      end else begin
         // Advance cycle: pipeline moves on, so both results are consumed.
         if (!ArbStall) begin
            iValid <= 1'b0;
            dValid <= 1'b0;
         end
         unique case (state)
            IDLE: begin
               // Data first: it belongs to the older instruction.
               if (dataReq && !dValid) begin
                  MemReq    <= 1'b1;
                  MemWe     <= MemWriteM;
                  MemAddr   <= ALUResultM;
                  MemWData  <= WriteDataM;
                  curIsData <= 1'b1;
                  state     <= REQ;
               end else if (FetchReqF && !iValid) begin
                  MemReq    <= 1'b1;
                  MemWe     <= 1'b0;
                  MemAddr   <= PCF;
                  curIsData <= 1'b0;
                  state     <= REQ;
               end
            end
            REQ: begin
               if (MemGnt) begin
                  MemReq <= 1'b0;
                  MemWe  <= 1'b0;
                  if (MemWe) begin
                     dValid <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (MemRValid) begin
                  if (curIsData) begin
                     ReadDataM <= MemRData;
                     dValid    <= 1'b1;
                  end else begin
                     InstrF <= MemRData;
                     iValid <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (reset) !(MemReadM && MemWriteM));

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter with a small responding memory.
// Expected values are hand-computed from the cycle behaviour of the arbiter.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCF, ALUResultM, WriteDataM;
   logic        FetchReqF, MemWriteM, MemReadM;
   logic [31:0] InstrF, ReadDataM;
   logic        ArbStall, MemReq, MemWe;
   logic [31:0] MemAddr, MemWData, MemRData;
   logic        MemGnt, MemRValid;
   logic        gntEn, rvEn;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] memRead(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h0050_0093;
         32'h0000_0104: return 32'h00A0_0113;
         32'h0000_2000: return 32'h1122_3344;
         32'h0000_2008: return 32'hCAFE_F00D;
         default:       return 32'h0000_0000;
      endcase
   endfunction

   assign MemGnt    = gntEn & MemReq;
   assign MemRValid = rvEn;
   assign MemRData  = memRead(MemAddr);

   unified_mem_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .PCF        (PCF),
      .FetchReqF  (FetchReqF),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .MemWriteM  (MemWriteM),
      .MemReadM   (MemReadM),
      .InstrF     (InstrF),
      .ReadDataM  (ReadDataM),
      .ArbStall   (ArbStall),
      .MemReq     (MemReq),
      .MemWe      (MemWe),
      .MemAddr    (MemAddr),
      .MemWData   (MemWData),
      .MemGnt     (MemGnt),
      .MemRValid  (MemRValid),
      .MemRData   (MemRData)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Steps cycles while ArbStall is high, logging request starts and request-high cycles.
   task automatic runStall(output int stalls, output int reqCycles,
                           output logic [31:0] addr0, output logic [31:0] addr1);
      int   starts;
      logic prevReq;
      bit   done;
      stalls = 0; reqCycles = 0; starts = 0; addr0 = '0; addr1 = '0;
      done = 1'b0;
      #1;
      prevReq = MemReq;
      for (int i = 0; i < 60; i++) begin
         if (!ArbStall) begin
            done = 1'b1;
            break;
         end
         stalls++;
         if (MemReq) reqCycles++;
         if (MemReq && !prevReq) begin
            if (starts == 0) addr0 = MemAddr;
            else addr1 = MemAddr;
            starts++;
         end
         prevReq = MemReq;
         tick();
      end
      if (!done) checkVal("stallTimeout", 32'd1, 32'd0);
   endtask

   int          stalls, reqCycles;
   logic [31:0] a0, a1;

   initial begin
      reset = 1'b1; PCF = '0; ALUResultM = '0; WriteDataM = '0;
      FetchReqF = 1'b0; MemWriteM = 1'b0; MemReadM = 1'b0;
      gntEn = 1'b0; rvEn = 1'b0;
      tick(); tick();
      reset = 1'b0;
      #1;
      checkVal("rstMemReq", {31'd0, MemReq}, 32'd0);
      checkVal("rstMemWe", {31'd0, MemWe}, 32'd0);
      checkVal("rstMemAddr", MemAddr, 32'd0);
      checkVal("rstInstrF", InstrF, 32'd0);
      checkVal("rstReadData", ReadDataM, 32'd0);
      checkVal("rstStall", {31'd0, ArbStall}, 32'd0);
      tick();

      // 1. Fetch only, immediate grant, data one cycle later.
      gntEn = 1'b1; rvEn = 1'b1;
      PCF = 32'h100; FetchReqF = 1'b1;
      runStall(stalls, reqCycles, a0, a1);
      checkVal("fetchStalls", stalls, 32'd3);
      checkVal("fetchReqCycles", reqCycles, 32'd1);
      checkVal("fetchAddr", a0, 32'h100);
      checkVal("fetchInstr", InstrF, 32'h0050_0093);
      FetchReqF = 1'b0;
      tick();
      checkVal("fetchHoldInstr", InstrF, 32'h0050_0093);
      checkVal("fetchIdleStall", {31'd0, ArbStall}, 32'd0);

      // 2. Load and fetch together: data served first, six stall cycles.
      MemReadM = 1'b1; ALUResultM = 32'h2000; PCF = 32'h104; FetchReqF = 1'b1;
      runStall(stalls, reqCycles, a0, a1);
      checkVal("lfStalls", stalls, 32'd6);
      checkVal("lfReqCycles", reqCycles, 32'd2);
      checkVal("lfAddr0", a0, 32'h2000);
      checkVal("lfAddr1", a1, 32'h104);
      checkVal("lfReadData", ReadDataM, 32'h1122_3344);
      checkVal("lfInstr", InstrF, 32'h00A0_0113);
      MemReadM = 1'b0; FetchReqF = 1'b0;
      tick();

      // 3. Store with grant held off for three cycles.
      gntEn = 1'b0; rvEn = 1'b0;
      MemWriteM = 1'b1; ALUResultM = 32'h2004; WriteDataM = 32'hDEAD_BEEF;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 3) gntEn = 1'b1;
         #1;
         checkVal("stReq", {31'd0, MemReq}, 32'd1);
         checkVal("stWe", {31'd0, MemWe}, 32'd1);
         checkVal("stAddr", MemAddr, 32'h2004);
         checkVal("stWData", MemWData, 32'hDEAD_BEEF);
         checkVal("stStall", {31'd0, ArbStall}, 32'd1);
         tick();
      end
      checkVal("stStallDrop", {31'd0, ArbStall}, 32'd0);
      checkVal("stReqDrop", {31'd0, MemReq}, 32'd0);
      checkVal("stReadDataHeld", ReadDataM, 32'h1122_3344);
      MemWriteM = 1'b0;
      tick();

      // 4. Load with read data withheld for ten cycles.
      gntEn = 1'b1; rvEn = 1'b0;
      MemReadM = 1'b1; ALUResultM = 32'h2008;
      tick(); tick();
      for (int i = 0; i < 10; i++) begin
         checkVal("bpStall", {31'd0, ArbStall}, 32'd1);
         checkVal("bpReadData", ReadDataM, 32'h1122_3344);
         checkVal("bpReq", {31'd0, MemReq}, 32'd0);
         tick();
      end
      rvEn = 1'b1;
      tick();
      checkVal("bpDone", ReadDataM, 32'hCAFE_F00D);
      checkVal("bpStallDrop", {31'd0, ArbStall}, 32'd0);
      rvEn = 1'b0; MemReadM = 1'b0;
      tick();

      // 5. Reset while waiting for read data, then a late read-valid pulse.
      MemReadM = 1'b1; ALUResultM = 32'h2000;
      tick(); tick();
      reset = 1'b1; MemReadM = 1'b0;
      tick();
      reset = 1'b0; rvEn = 1'b1;
      tick();
      rvEn = 1'b0;
      tick();
      checkVal("rsMemReq", {31'd0, MemReq}, 32'd0);
      checkVal("rsMemWe", {31'd0, MemWe}, 32'd0);
      checkVal("rsMemAddr", MemAddr, 32'd0);
      checkVal("rsMemWData", MemWData, 32'd0);
      checkVal("rsInstrF", InstrF, 32'd0);
      checkVal("rsReadData", ReadDataM, 32'd0);
      checkVal("rsStall", {31'd0, ArbStall}, 32'd0);

      // 6. Idle for five cycles, then a fetch must launch straight from IDLE.
      for (int i = 0; i < 5; i++) begin
         checkVal("idleReq", {31'd0, MemReq}, 32'd0);
         checkVal("idleStall", {31'd0, ArbStall}, 32'd0);
         tick();
      end
      gntEn = 1'b1; rvEn = 1'b1;
      PCF = 32'h100; FetchReqF = 1'b1;
      tick();
      checkVal("idleLaunchReq", {31'd0, MemReq}, 32'd1);
      checkVal("idleLaunchAddr", MemAddr, 32'h100);
      FetchReqF = 1'b0;
      tick(); tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
